// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for the shared ALU arbiter: two request ports with
// their operands, plus grant/done handshakes and the shared result bus.
interface alu_arbiter_if;
    logic       req0;
    logic [3:0] sel0;
    logic [7:0] opa0;
    logic [7:0] opb0;
    logic       req1;
    logic [3:0] sel1;
    logic [7:0] opa1;
    logic [7:0] opb1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] res_out;
    logic       zero_out;
    logic       err;

    // Requester view: drives requests and operands, sees grants and results.
    modport master (
        output req0, sel0, opa0, opb0, req1, sel1, opa1, opb1,
        input  gnt0, gnt1, done0, done1, res_out, zero_out, err
    );

    // Arbiter view: the mirror image of the requester view.
    modport slave (
        input  req0, sel0, opa0, opb0, req1, sel1, opa1, opb1,
        output gnt0, gnt1, done0, done1, res_out, zero_out, err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters.
// The winner's operands and SELECT are registered onto the ALU inputs.
// They are held for an opcode-dependent number of cycles, then the result
// and zero flag are captured and returned with a one-cycle DONE pulse.
module alu_arbiter #(
    parameter int LAT_BASIC = 2,
    parameter int LAT_MULT  = 4,
    parameter int CNT_W     = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    alu_arbiter_if.slave     bus,
    output logic [7:0]       o_alu_data1,
    output logic [7:0]       o_alu_data2,
    output logic [3:0]       o_alu_select,
    input  logic [7:0]       i_alu_result,
    input  logic             i_alu_zero
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;     // port that completed the most recent operation
    logic             r_owner;    // port currently holding the ALU
    logic             r_illegal;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done0;
    logic             r_done1;
    logic [7:0]       r_res;
    logic             r_zero;
    logic             r_err;
    logic [7:0]       r_d1;
    logic [7:0]       r_d2;
    logic [3:0]       r_sel;

    // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
    wire logic       w_any   = bus.req0 | bus.req1;
    wire logic       w_pick1 = bus.req1 & (~bus.req0 | ~r_last);
    wire logic [3:0] w_sel   = w_pick1 ? bus.sel1 : bus.sel0;
    wire logic [7:0] w_opa   = w_pick1 ? bus.opa1 : bus.opa0;
    wire logic [7:0] w_opb   = w_pick1 ? bus.opb1 : bus.opb0;

    // Cycles to wait after grant, minus one; illegal codes complete immediately.
    function automatic logic [CNT_W-1:0] lat_load(input logic [3:0] sel);
        if (sel == 4'b1000)
            return CNT_W'(LAT_MULT - 1);
        else if (!sel[3])
            return CNT_W'(LAT_BASIC - 1);
        else
            return '0;
    endfunction

    // Arbitration, latency timing and result capture.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_illegal <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_res     <= '0;
            r_zero    <= 1'b0;
            r_err     <= 1'b0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_sel     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner   <= w_pick1;
                        r_gnt0    <= ~w_pick1;
                        r_gnt1    <= w_pick1;
                        r_d1      <= w_opa;
                        r_d2      <= w_opb;
                        r_sel     <= w_sel;
                        r_cnt     <= lat_load(w_sel);
                        r_illegal <= w_sel[3] & (w_sel[2:0] != 3'b000);
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        if (r_illegal) begin
                            r_res  <= '0;
                            r_zero <= 1'b1;
                            r_err  <= 1'b1;
                        end else begin
                            r_res  <= i_alu_result;
                            r_zero <= i_alu_zero;
                            r_err  <= 1'b0;
                        end
                        r_last  <= r_owner;
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt0     = r_gnt0;
    assign bus.gnt1     = r_gnt1;
    assign bus.done0    = r_done0;
    assign bus.done1    = r_done1;
    assign bus.res_out  = r_res;
    assign bus.zero_out = r_zero;
    assign bus.err      = r_err;
    assign o_alu_data1  = r_d1;
    assign o_alu_data2  = r_d2;
    assign o_alu_select = r_sel;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios followed by randomized traffic,
// compared every cycle against a transaction-level timeline model.
module tb_alu_arbiter;
    localparam int LB = 2;
    localparam int LM = 4;

    logic       clk;
    logic       rst;
    logic [7:0] alu_d1;
    logic [7:0] alu_d2;
    logic [3:0] alu_sel;
    logic [7:0] alu_res;
    logic       alu_zero;

    alu_arbiter_if bus ();

    alu_arbiter #(.LAT_BASIC(LB), .LAT_MULT(LM), .CNT_W(3)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .bus          (bus),
        .o_alu_data1  (alu_d1),
        .o_alu_data2  (alu_d2),
        .o_alu_select (alu_sel),
        .i_alu_result (alu_res),
        .i_alu_zero   (alu_zero)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Behavioural ALU: {zero, result}; undefined codes return a nonzero pattern.
    function automatic logic [8:0] alu_fn(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0]  r;
        logic [15:0] m;
        m = {8'h00, a} * {8'h00, b};
        case (s)
            4'd0: r = a;
            4'd1: r = a + b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a >> 1;
            4'd5: r = a << 1;
            4'd6: r = {a[0], a[7:1]};
            4'd7: r = {a[7], a[7:1]};
            4'd8: r = m[7:0];
            default: return {1'b0, 8'hA5};
        endcase
        return {(r == 8'h00), r};
    endfunction

    always_comb {alu_zero, alu_res} = alu_fn(alu_sel, alu_d1, alu_d2);

    int errors = 0;
    int checks = 0;

    // Timeline model: one in-flight transaction described by its grant edge and length.
    int         edge_n = 0;
    bit         act = 0;
    int         t_g, t_L, t_w;
    int         free_edge = 0;
    int         last_w = 1;
    logic [7:0] m_res, m_d1, m_d2;
    logic [3:0] m_sel;
    logic       m_zero, m_err;
    logic [8:0] fz;

    function automatic int op_len(input logic [3:0] s);
        if (s == 4'd8) return LM;
        if (s < 4'd8)  return LB;
        return 1;
    endfunction

    task automatic model_step();
        int w;
        edge_n++;
        if (rst) begin
            act = 0; last_w = 1; free_edge = edge_n + 1;
            m_res = 0; m_zero = 0; m_err = 0; m_d1 = 0; m_d2 = 0; m_sel = 0;
        end else begin
            if (act && edge_n == t_g + t_L + 1) act = 0;
            if (!act && edge_n >= free_edge && (bus.req0 || bus.req1)) begin
                if (bus.req0 && bus.req1) w = 1 - last_w;
                else w = bus.req0 ? 0 : 1;
                act = 1; t_g = edge_n; t_w = w;
                m_d1  = w ? bus.opa1 : bus.opa0;
                m_d2  = w ? bus.opb1 : bus.opb0;
                m_sel = w ? bus.sel1 : bus.sel0;
                t_L = op_len(m_sel);
                free_edge = edge_n + t_L + 2;
            end
            if (act && edge_n == t_g + t_L) begin
                if (m_sel > 4'd8) begin
                    m_res = 0; m_zero = 1; m_err = 1;
                end else begin
                    fz = alu_fn(m_sel, m_d1, m_d2);
                    m_res = fz[7:0]; m_zero = fz[8]; m_err = 0;
                end
                last_w = t_w;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic tick();
        bit dn;
        model_step();
        @(posedge clk);
        #1;
        dn = act && edge_n == t_g + t_L;
        chk("gnt0",  bus.gnt0,  act && t_w == 0);
        chk("gnt1",  bus.gnt1,  act && t_w == 1);
        chk("done0", bus.done0, dn && t_w == 0);
        chk("done1", bus.done1, dn && t_w == 1);
        chk("res",   bus.res_out, m_res);
        chk("zero",  bus.zero_out, m_zero);
        chk("err",   bus.err, m_err);
        chk("alu_d1", alu_d1, m_d1);
        chk("alu_d2", alu_d2, m_d2);
        chk("alu_sel", alu_sel, m_sel);
    endtask

    task automatic wait_done(input int budget, output int who);
        who = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.done0) begin who = 0; break; end
            if (bus.done1) begin who = 1; break; end
        end
        checks++;
        assert (who != -1) else begin
            errors++;
            $error("FAIL done_timeout @edge %0d: observed=none expected=DONE within %0d cycles", edge_n, budget);
        end
    endtask

    task automatic set0(input logic r, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        bus.req0 = r; bus.sel0 = s; bus.opa0 = a; bus.opb0 = b;
    endtask

    task automatic set1(input logic r, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        bus.req1 = r; bus.sel1 = s; bus.opa1 = a; bus.opb1 = b;
    endtask

    initial begin
        int who;
        int order [4];
        rst = 1'b1;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);

        // Reset state
        tick();
        chk("rst_res", bus.res_out, 8'h00);
        chk("rst_gnt", {bus.gnt0, bus.gnt1}, 2'b00);
        rst = 1'b0;

        // Single add
        set0(1, 4'b0001, 8'd5, 8'd3);
        tick();
        chk("add_gnt0", bus.gnt0, 1'b1);
        tick();
        tick();
        chk("add_done0", bus.done0, 1'b1);
        chk("add_res", bus.res_out, 8'd8);
        chk("add_zero", bus.zero_out, 1'b0);
        chk("add_gnt1", bus.gnt1, 1'b0);
        bus.req0 = 0;
        tick();

        // Multiply on port 1
        set1(1, 4'b1000, 8'd6, 8'd7);
        tick();
        chk("mul_gnt1", bus.gnt1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mul_sel_held", alu_sel, 4'b1000);
        end
        tick();
        chk("mul_done1", bus.done1, 1'b1);
        chk("mul_res", bus.res_out, 8'd42);
        bus.req1 = 0;
        tick();

        // Contention with both requests held high
        set0(1, 4'b0010, 8'hF0, 8'h3C);
        set1(1, 4'b0011, 8'hF0, 8'h0F);
        for (int k = 0; k < 4; k++) begin
            wait_done(12, who);
            order[k] = who;
            if (who == 0) chk("rr_res0", bus.res_out, 8'h30);
            if (who == 1) chk("rr_res1", bus.res_out, 8'hFF);
        end
        chk("rr_order0", order[0], 0);
        chk("rr_order1", order[1], 1);
        chk("rr_order2", order[2], 0);
        chk("rr_order3", order[3], 1);
        bus.req0 = 0; bus.req1 = 0;
        tick();
        tick();

        // Zero flag from add(5, FB)
        set0(1, 4'b0001, 8'h05, 8'hFB);
        wait_done(8, who);
        chk("zf_res", bus.res_out, 8'h00);
        chk("zf_zero", bus.zero_out, 1'b1);
        bus.req0 = 0;
        tick();

        // Illegal code
        set0(1, 4'b1011, 8'h12, 8'h34);
        tick();
        tick();
        chk("ill_done0", bus.done0, 1'b1);
        chk("ill_res", bus.res_out, 8'h00);
        chk("ill_zero", bus.zero_out, 1'b1);
        chk("ill_err", bus.err, 1'b1);
        bus.req0 = 0;
        tick();

        // Reset in the middle of a port-1 multiply
        set1(1, 4'b1000, 8'd9, 8'd9);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rmid_gnt1", bus.gnt1, 1'b0);
        chk("rmid_done1", bus.done1, 1'b0);
        chk("rmid_res", bus.res_out, 8'h00);
        rst = 1'b0;
        set0(1, 4'b0000, 8'h77, 8'h00);
        set1(1, 4'b0001, 8'h01, 8'h02);
        tick();
        chk("rmid_tie_gnt0", bus.gnt0, 1'b1);
        chk("rmid_tie_gnt1", bus.gnt1, 1'b0);
        wait_done(8, who);
        bus.req0 = 0; bus.req1 = 0;
        tick();
        tick();

        // Operand change and request drop during execution
        set0(1, 4'b0001, 8'd10, 8'd20);
        tick();
        bus.opa0 = 8'd99;
        bus.req0 = 0;
        tick();
        tick();
        chk("opchg_done0", bus.done0, 1'b1);
        chk("opchg_res", bus.res_out, 8'd30);
        tick();
        tick();
        chk("opchg_once", bus.done0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            set0($urandom_range(0, 3) != 0, 4'($urandom_range(0, 10)), 8'($urandom), 8'($urandom));
            set1($urandom_range(0, 3) != 0, 4'($urandom_range(0, 10)), 8'($urandom), 8'($urandom));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
